// File: rtl/button_speed_select.sv
// Debounces five push-buttons and turns debounced rising edges into a sticky
// one-hot speed selection with a change strobe.

module button_speed_select_lane #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LASTI = (DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0;
  localparam logic [CW-1:0] LAST = CW'(LASTI);

  typedef enum logic [1:0] {
    LOW_STABLE   = 2'b00,
    LOW_PENDING  = 2'b01,
    HIGH_STABLE  = 2'b10,
    HIGH_PENDING = 2'b11
  } state_e;

  logic [1:0]    sync_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, rise_d;
  logic          sync;

  assign sync = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= LOW_STABLE;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  // The cycle that leaves *_STABLE is the first of the DEBOUNCE_CYCLES stable
  // samples, so PENDING accepts once its count reaches DEBOUNCE_CYCLES-2.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOW_STABLE: if (sync) begin
        cnt_d   = '0;
        state_d = (DEBOUNCE_CYCLES == 1) ? HIGH_STABLE : LOW_PENDING;
      end
      LOW_PENDING: begin
        if (!sync) begin
          state_d = LOW_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = HIGH_STABLE;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HIGH_STABLE: if (!sync) begin
        cnt_d   = '0;
        state_d = (DEBOUNCE_CYCLES == 1) ? LOW_STABLE : HIGH_PENDING;
      end
      HIGH_PENDING: begin
        if (sync) begin
          state_d = HIGH_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = LOW_STABLE;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = LOW_STABLE;
        cnt_d   = '0;
      end
    endcase
    rise_d = !state_q[1] && (state_d == HIGH_STABLE);
  end

  assign level = state_q[1];
  assign rise  = rise_q;
endmodule

module button_speed_select #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_raw,
  output logic [4:0] btn_level,
  output logic [4:0] btn_rise,
  output logic [4:0] speed_sel,
  output logic       sel_changed
);
  localparam int NUM_LANES = 5;

  logic [NUM_LANES-1:0] pick;
  logic [NUM_LANES-1:0] sel_q;
  logic                 chg_q;

  button_speed_select_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane [NUM_LANES-1:0] (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_raw),
    .level(btn_level),
    .rise (btn_rise)
  );

  // Isolate the lowest set bit so simultaneous presses resolve to the lowest index.
  assign pick = btn_rise & (~btn_rise + 5'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= 5'b00001;
      chg_q <= 1'b0;
    end else begin
      chg_q <= 1'b0;
      if (|btn_rise) begin
        sel_q <= pick;
        chg_q <= (pick != sel_q);
      end
    end
  end

  assign speed_sel   = sel_q;
  assign sel_changed = chg_q;
endmodule

// File: tb/tb_button_speed_select.sv
// Cycle-accurate check of button_speed_select with DEBOUNCE_CYCLES=4: expected
// outputs are queued as each cycle's stimulus is driven and popped after the edge.

module tb_button_speed_select;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn_raw;
  logic [4:0] btn_level, btn_rise, speed_sel;
  logic       sel_changed;

  button_speed_select #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_rise   (btn_rise),
    .speed_sel  (speed_sel),
    .sel_changed(sel_changed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] raw;
    logic [4:0] lvl;
    logic [4:0] rise;
    logic [4:0] sel;
    logic       chg;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // A raw step held from j=0 shows on btn_level/btn_rise after edge 6 (j=5)
  // and on speed_sel/sel_changed one edge later (j=6).
  task automatic seg(input logic [4:0] raw, input int n,
                     input logic [4:0] lvl_b, input logic [4:0] lvl_a,
                     input logic [4:0] rise, input logic [4:0] sel_b,
                     input logic [4:0] sel_a, input logic chg);
    vec_t v;
    for (int j = 0; j < n; j++) begin
      v.raw  = raw;
      v.lvl  = (j >= 5) ? lvl_a : lvl_b;
      v.rise = (j == 5) ? rise : 5'b0;
      v.sel  = (j >= 6) ? sel_a : sel_b;
      v.chg  = (j == 6) ? chg : 1'b0;
      tbl.push_back(v);
    end
  endtask

  task automatic compare(input string nm, input vec_t e);
    n_vec++;
    if (btn_level !== e.lvl || btn_rise !== e.rise || speed_sel !== e.sel ||
        sel_changed !== e.chg) begin
      n_bad++;
      $display("FAIL %s #%0d: got level=%b rise=%b sel=%b chg=%b, want level=%b rise=%b sel=%b chg=%b",
               nm, n_vec, btn_level, btn_rise, speed_sel, sel_changed,
               e.lvl, e.rise, e.sel, e.chg);
    end
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    vec_t e;
    btn_raw = v.raw;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compare(nm, e);
  endtask

  task automatic apply_tbl(input string nm);
    while (tbl.size() > 0) run_vec(nm, tbl.pop_front());
  endtask

  vec_t rv, iv;

  initial begin
    rv = '{raw: 5'b0, lvl: 5'b0, rise: 5'b0, sel: 5'b00001, chg: 1'b0};
    rst     = 1'b1;
    btn_raw = 5'b0;
    repeat (3) @(posedge clk);
    #1;
    compare("reset_state", rv);
    rst = 1'b0;

    // Idle after reset: no activity for 100 cycles.
    for (int k = 0; k < 100; k++) run_vec("idle", rv);

    // Table: re-press current selection, step/release bit 3, glitch on bit 2,
    // simultaneous bits 1 and 2.
    seg(5'b00001,  8, 5'b00000, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 1'b0);
    seg(5'b00000,  8, 5'b00001, 5'b00000, 5'b00000, 5'b00001, 5'b00001, 1'b0);
    seg(5'b01000, 10, 5'b00000, 5'b01000, 5'b01000, 5'b00001, 5'b01000, 1'b1);
    seg(5'b00000,  8, 5'b01000, 5'b00000, 5'b00000, 5'b01000, 5'b01000, 1'b0);
    seg(5'b00100,  3, 5'b00000, 5'b00000, 5'b00000, 5'b01000, 5'b01000, 1'b0);
    seg(5'b00000,  8, 5'b00000, 5'b00000, 5'b00000, 5'b01000, 5'b01000, 1'b0);
    seg(5'b00110,  9, 5'b00000, 5'b00110, 5'b00110, 5'b01000, 5'b00010, 1'b1);
    seg(5'b00000,  8, 5'b00110, 5'b00000, 5'b00000, 5'b00010, 5'b00010, 1'b0);
    apply_tbl("table");

    // Reset in the middle of a bit-4 debounce with the button held.
    iv = '{raw: 5'b10000, lvl: 5'b0, rise: 5'b0, sel: 5'b00010, chg: 1'b0};
    for (int k = 0; k < 3; k++) run_vec("pre_rst", iv);
    rst = 1'b1;
    #1;
    compare("async_rst", '{raw: 5'b10000, lvl: 5'b0, rise: 5'b0, sel: 5'b00001, chg: 1'b0});
    for (int k = 0; k < 2; k++)
      run_vec("in_rst", '{raw: 5'b10000, lvl: 5'b0, rise: 5'b0, sel: 5'b00001, chg: 1'b0});
    rst = 1'b0;
    seg(5'b10000, 9, 5'b00000, 5'b10000, 5'b10000, 5'b00001, 5'b10000, 1'b1);
    apply_tbl("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
